// File: rtl/sdc_clk_pkg.sv
// Shared types and default constants for the multi-channel SD card clock generator.
package sdc_clk_pkg;

    // Default build parameters of the generator.
    localparam int SDC_NCH_DEF       = 2;
    localparam int SDC_DIV_BITS_DEF  = 8;
    localparam int SDC_RESET_DIV_DEF = 255;

    // Per-channel pad clock state. STOPPED parks the pad low.
    typedef enum logic [1:0] {
        SDC_STOPPED = 2'd0,
        SDC_HIGH    = 2'd1,
        SDC_LOW     = 2'd2
    } sdc_clk_state_t;

    // A phase lasts div+1 cycles: it ends on the cycle where the counter reaches div.
    function automatic logic sdc_phase_end(input logic [31:0] cnt, input logic [31:0] div);
        return (cnt == div);
    endfunction

endpackage

// File: rtl/sdc_clkgen_ch.sv
// One SD card clock channel: 50% duty divider with a glitch-free divider update,
// a park-low stop handshake and registered rise/fall clock-enable strobes.
module sdc_clkgen_ch
    import sdc_clk_pkg::*;
#(
    parameter int DIV_BITS  = SDC_DIV_BITS_DEF,
    parameter int RESET_DIV = SDC_RESET_DIV_DEF
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [DIV_BITS-1:0] div_value_i,
    input  logic                div_load_i,
    input  logic                stop_req_i,
    output logic                div_ack_o,
    output logic                stopped_o,
    output logic                clk_pad_o,
    output logic                ce_rise_o,
    output logic                ce_fall_o
);

    sdc_clk_state_t      state_q,    state_d;
    logic [DIV_BITS-1:0] cnt_q,      cnt_d;
    logic [DIV_BITS-1:0] div_act_q,  div_act_d;
    logic [DIV_BITS-1:0] div_pend_q, div_pend_d;
    logic                pend_q,     pend_d;
    logic                clk_pad_q;
    logic                stopped_q;
    logic                ce_rise_q,  ce_rise_d;
    logic                ce_fall_q,  ce_fall_d;
    logic                div_ack_q,  div_ack_d;

    logic                phase_end;
    logic                apply_slot;

    // The current phase (high or low) finishes on this cycle.
    assign phase_end  = sdc_phase_end(32'(cnt_q), 32'(div_act_q));

    // The divider may only change where no period is in flight: while parked,
    // or on the last cycle of a low phase.
    assign apply_slot = (state_q == SDC_STOPPED) ||
                        ((state_q == SDC_LOW) && phase_end);

    // Next-state logic: phase sequencing plus pending-divider bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        ce_rise_d  = 1'b0;
        ce_fall_d  = 1'b0;
        div_ack_d  = 1'b0;

        unique case (state_q)
            SDC_STOPPED: begin
                if (!stop_req_i) begin
                    state_d   = SDC_HIGH;
                    cnt_d     = '0;
                    ce_rise_d = 1'b1;
                end
            end
            SDC_HIGH: begin
                if (phase_end) begin
                    state_d   = SDC_LOW;
                    cnt_d     = '0;
                    ce_fall_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_BITS'(1);
                end
            end
            SDC_LOW: begin
                if (phase_end) begin
                    // Stop is only looked at here, so a full low phase always
                    // precedes parking and a short stop pulse is simply ignored.
                    cnt_d = '0;
                    if (stop_req_i) begin
                        state_d = SDC_STOPPED;
                    end else begin
                        state_d   = SDC_HIGH;
                        ce_rise_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_BITS'(1);
                end
            end
            default: begin
                state_d = SDC_STOPPED;
                cnt_d   = '0;
            end
        endcase

        // A load arriving in an apply slot bypasses the pending register;
        // otherwise it overwrites any earlier unapplied value.
        if (apply_slot) begin
            if (div_load_i) begin
                div_act_d = div_value_i;
                div_ack_d = 1'b1;
            end else if (pend_q) begin
                div_act_d = div_pend_q;
                div_ack_d = 1'b1;
            end
            pend_d = 1'b0;
        end else if (div_load_i) begin
            div_pend_d = div_value_i;
            pend_d     = 1'b1;
        end
    end

    // State and output registers; the pad level is derived from the next state
    // so every output is a flop with no input-to-output combinational path.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= SDC_STOPPED;
            cnt_q      <= '0;
            div_act_q  <= DIV_BITS'(RESET_DIV);
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_pad_q  <= 1'b0;
            stopped_q  <= 1'b1;
            ce_rise_q  <= 1'b0;
            ce_fall_q  <= 1'b0;
            div_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_pad_q  <= (state_d == SDC_HIGH);
            stopped_q  <= (state_d == SDC_STOPPED);
            ce_rise_q  <= ce_rise_d;
            ce_fall_q  <= ce_fall_d;
            div_ack_q  <= div_ack_d;
        end
    end

    assign clk_pad_o = clk_pad_q;
    assign stopped_o = stopped_q;
    assign ce_rise_o = ce_rise_q;
    assign ce_fall_o = ce_fall_q;
    assign div_ack_o = div_ack_q;

endmodule

// File: rtl/sdc_clkgen_multi.sv
// Multi-channel SD card clock generator: NCH fully independent clock channels
// sharing only the input clock and reset.
module sdc_clkgen_multi
    import sdc_clk_pkg::*;
#(
    parameter int NCH       = SDC_NCH_DEF,
    parameter int DIV_BITS  = SDC_DIV_BITS_DEF,
    parameter int RESET_DIV = SDC_RESET_DIV_DEF
) (
    input  logic                    sd_clk_in,
    input  logic                    sd_rst_in,
    input  logic [NCH*DIV_BITS-1:0] div_value,
    input  logic [NCH-1:0]          div_load,
    output logic [NCH-1:0]          div_ack,
    input  logic [NCH-1:0]          stop_req,
    output logic [NCH-1:0]          stopped,
    output logic [NCH-1:0]          clk_pad,
    output logic [NCH-1:0]          ce_rise,
    output logic [NCH-1:0]          ce_fall
);

    // One channel per lane; divider slice i drives channel i.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            sdc_clkgen_ch #(
                .DIV_BITS  (DIV_BITS),
                .RESET_DIV (RESET_DIV)
            ) u_ch (
                .clk         (sd_clk_in),
                .srst        (sd_rst_in),
                .div_value_i (div_value[gi*DIV_BITS +: DIV_BITS]),
                .div_load_i  (div_load[gi]),
                .stop_req_i  (stop_req[gi]),
                .div_ack_o   (div_ack[gi]),
                .stopped_o   (stopped[gi]),
                .clk_pad_o   (clk_pad[gi]),
                .ce_rise_o   (ce_rise[gi]),
                .ce_fall_o   (ce_fall[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sdc_clkgen_multi.sv
// Scoreboard bench for sdc_clkgen_multi: expected event latencies are queued when
// stimulus is driven and compared when the matching DUT event is observed.
module tb_sdc_clkgen_multi;

    localparam int NCH = 2;
    localparam int DB  = 8;

    localparam int S_RISE = 0;
    localparam int S_FALL = 1;
    localparam int S_ACK  = 2;
    localparam int S_STOP = 3;
    localparam int S_PAD  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DB-1:0] div_value = '0;
    logic [NCH-1:0]    div_load  = '0;
    logic [NCH-1:0]    stop_req  = '0;
    logic [NCH-1:0]    div_ack, stopped, clk_pad, ce_rise, ce_fall;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ack_cnt1 = 0;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (div_ack[1]) ack_cnt1 <= ack_cnt1 + 1;

    sdc_clkgen_multi #(
        .NCH       (NCH),
        .DIV_BITS  (DB),
        .RESET_DIV (255)
    ) dut (
        .sd_clk_in (clk),
        .sd_rst_in (rst),
        .div_value (div_value),
        .div_load  (div_load),
        .div_ack   (div_ack),
        .stop_req  (stop_req),
        .stopped   (stopped),
        .clk_pad   (clk_pad),
        .ce_rise   (ce_rise),
        .ce_fall   (ce_fall)
    );

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input int act);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            $display("[cyc %0d] %s: observed %0d, expected %0d", cyc, e.tag, act, e.exp);
            check_val(e.tag, act, e.exp);
        end
    endtask

    function automatic logic get_sig(input int ch, input int which);
        case (which)
            S_RISE:  return ce_rise[ch];
            S_FALL:  return ce_fall[ch];
            S_ACK:   return div_ack[ch];
            S_STOP:  return stopped[ch];
            default: return clk_pad[ch];
        endcase
    endfunction

    // Waits (bounded) for a DUT strobe; n is the number of clock edges taken or -1.
    task automatic wait_sig(input int ch, input int which, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (get_sig(ch, which)) begin
                n = i;
                break;
            end
        end
    endtask

    // Same, but reports the cycle distance from stamp t0 (or -1 on timeout).
    task automatic wait_rel(input int ch, input int which, input int maxc, input int t0,
                            output int d);
        int n;
        wait_sig(ch, which, maxc, n);
        d = (n > 0) ? (cyc - t0) : -1;
    endtask

    initial begin
        int n, d, t0, cr, cf, pad_hi, ack_before;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_clk_pad", int'(clk_pad), 0);
        check_val("rst_stopped", int'(stopped), 3);
        check_val("rst_ce_rise", int'(ce_rise), 0);
        check_val("rst_ce_fall", int'(ce_fall), 0);
        check_val("rst_div_ack", int'(div_ack), 0);

        // ---------------- T1: free run at RESET_DIV ----------------
        rst = 1'b0;
        sb_push("t1_first_rise", 1);
        wait_sig(0, S_RISE, 10, n);
        sb_pop_check(n);
        check_val("t1_ch1_rise", int'(ce_rise[1]), 1);
        check_val("t1_pad_high", int'(clk_pad[0]), 1);
        t0 = cyc;
        sb_push("t1_high_len", 256);
        wait_rel(0, S_FALL, 300, t0, d);
        sb_pop_check(d);
        check_val("t1_pad_low", int'(clk_pad[0]), 0);
        t0 = cyc;
        sb_push("t1_low_len", 256);
        wait_rel(0, S_RISE, 300, t0, d);
        sb_pop_check(d);
        check_val("t1_running", int'(stopped[0]), 0);

        // park both channels: request at HIGH cnt 0 -> parked after 512 edges
        stop_req = 2'b11;
        sb_push("t1_stop_lat", 512);
        wait_sig(0, S_STOP, 600, n);
        sb_pop_check(n);
        check_val("t1_ch1_stopped", int'(stopped[1]), 1);

        // ---------------- T2: ch0 load 3 while stopped ----------------
        div_value[0 +: DB] = 8'd3;
        div_load[0] = 1'b1;
        sb_push("t2_ack_stopped", 1);
        @(negedge clk);
        div_load[0] = 1'b0;
        sb_pop_check(int'(div_ack[0]));
        stop_req[0] = 1'b0;
        sb_push("t2_release_rise", 1);
        wait_sig(0, S_RISE, 10, n);
        sb_pop_check(n);
        t0 = cyc;
        sb_push("t2_high_len", 4);
        wait_rel(0, S_FALL, 20, t0, d);
        sb_pop_check(d);
        t0 = cyc;
        sb_push("t2_low_len", 4);
        wait_rel(0, S_RISE, 20, t0, d);
        sb_pop_check(d);
        cr = 0;
        cf = 0;
        repeat (8) begin
            @(negedge clk);
            cr += int'(ce_rise[0]);
            cf += int'(ce_fall[0]);
        end
        check_val("t2_rise_per_period", cr, 1);
        check_val("t2_fall_per_period", cf, 1);

        // ---------------- T3: ch1 at div 4, two loads mid-HIGH ----------------
        div_value[DB +: DB] = 8'd4;
        div_load[1] = 1'b1;
        sb_push("t3_ack_stopped", 1);
        @(negedge clk);
        div_load[1] = 1'b0;
        sb_pop_check(int'(div_ack[1]));
        stop_req[1] = 1'b0;
        sb_push("t3_release_rise", 1);
        wait_sig(1, S_RISE, 10, n);
        sb_pop_check(n);
        t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        div_value[DB +: DB] = 8'd1;
        div_load[1] = 1'b1;
        @(negedge clk);
        div_value[DB +: DB] = 8'd2;
        @(negedge clk);
        div_load[1] = 1'b0;
        sb_push("t3_high_len_kept", 5);
        wait_rel(1, S_FALL, 20, t0, d);
        sb_pop_check(d);
        sb_push("t3_ack_at_boundary", 10);
        wait_rel(1, S_ACK, 20, t0, d);
        sb_pop_check(d);
        check_val("t3_ack_with_rise", int'(ce_rise[1]), 1);
        t0 = cyc;
        sb_push("t3_new_high_len", 3);
        wait_rel(1, S_FALL, 20, t0, d);
        sb_pop_check(d);
        t0 = cyc;
        sb_push("t3_new_low_len", 3);
        wait_rel(1, S_RISE, 20, t0, d);
        sb_pop_check(d);

        // ---------------- T4: ch0 div 2, stop at LOW cnt 0 ----------------
        div_value[0 +: DB] = 8'd2;
        div_load[0] = 1'b1;
        @(negedge clk);
        div_load[0] = 1'b0;
        sb_push("t4_ack_seen", 1);
        wait_sig(0, S_ACK, 20, n);
        sb_pop_check((n > 0) ? 1 : 0);
        check_val("t4_ack_with_rise", int'(ce_rise[0]), 1);
        t0 = cyc;
        sb_push("t4_high_len", 3);
        wait_rel(0, S_FALL, 20, t0, d);
        sb_pop_check(d);
        stop_req[0] = 1'b1;
        pad_hi = 0;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (clk_pad[0]) pad_hi++;
            if (stopped[0]) begin
                n = i;
                break;
            end
        end
        sb_push("t4_stop_lat", 3);
        sb_pop_check(n);
        check_val("t4_pad_held_low", pad_hi, 0);
        stop_req[0] = 1'b0;
        sb_push("t4_release_rise", 1);
        wait_sig(0, S_RISE, 10, n);
        sb_pop_check(n);
        check_val("t4_release_pad", int'(clk_pad[0]), 1);
        check_val("t4_release_run", int'(stopped[0]), 0);

        // ---------------- T5: stop glitch in HIGH, load at boundary ----------------
        t0 = cyc;
        stop_req[0] = 1'b1;
        @(negedge clk);
        stop_req[0] = 1'b0;
        sb_push("t5_fall_after_glitch", 3);
        wait_rel(0, S_FALL, 20, t0, d);
        sb_pop_check(d);
        sb_push("t5_period_after_glitch", 6);
        wait_rel(0, S_RISE, 20, t0, d);
        sb_pop_check(d);
        check_val("t5_not_stopped", int'(stopped[0]), 0);
        wait_sig(0, S_FALL, 20, n);
        @(negedge clk);
        @(negedge clk);
        div_value[0 +: DB] = 8'd0;
        div_load[0] = 1'b1;
        @(negedge clk);
        div_load[0] = 1'b0;
        sb_push("t5_ack_same_boundary", 1);
        sb_pop_check(int'(div_ack[0]));
        check_val("t5_rise_at_boundary", int'(ce_rise[0]), 1);
        t0 = cyc;
        sb_push("t5_div0_high", 1);
        wait_rel(0, S_FALL, 10, t0, d);
        sb_pop_check(d);
        sb_push("t5_div0_period", 2);
        wait_rel(0, S_RISE, 10, t0, d);
        sb_pop_check(d);

        // ---------------- T6: reset mid-HIGH with a pending load ----------------
        wait_sig(1, S_RISE, 20, n);
        check_val("t6_ch1_rise_found", (n > 0) ? 1 : 0, 1);
        div_value[DB +: DB] = 8'd7;
        div_load[1] = 1'b1;
        @(negedge clk);
        div_load[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_pad", int'(clk_pad), 0);
        check_val("t6_rst_stopped", int'(stopped), 3);
        check_val("t6_rst_ack", int'(div_ack), 0);
        rst = 1'b0;
        ack_before = ack_cnt1;
        sb_push("t6_release_rise", 1);
        wait_sig(1, S_RISE, 10, n);
        sb_pop_check(n);
        t0 = cyc;
        sb_push("t6_reset_div_high", 256);
        wait_rel(1, S_FALL, 300, t0, d);
        sb_pop_check(d);
        t0 = cyc;
        sb_push("t6_reset_div_low", 256);
        wait_rel(1, S_RISE, 300, t0, d);
        sb_pop_check(d);
        @(negedge clk);
        check_val("t6_no_ack_after_rst", ack_cnt1 - ack_before, 0);
        check_val("t6_scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
